// File: rtl/control_pkg.sv
// Shared types and constants for the multi-cycle control FSM and its
// instruction decoder.
package control_pkg;

    // FSM state encoding (also exported on state_dbg)
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // Instruction classes resolved at decode; CL_NOP covers undefined encodings
    typedef enum logic [2:0] {
        CL_NOP   = 3'd0,
        CL_RALU  = 3'd1,
        CL_IALU  = 3'd2,
        CL_SHIFT = 3'd3,
        CL_LOAD  = 3'd4,
        CL_STOR  = 3'd5,
        CL_JUMP  = 3'd6,
        CL_BCOND = 3'd7
    } iclass_t;

    typedef struct packed {
        iclass_t cls;
        logic    is_cmp;     // CMP / CMPI: update flags, skip writeback
        logic    sign_ext;   // immediate is sign extended
        logic    shift_imm;  // shift amount comes from the immediate
        logic    br_taken;   // Bcond condition holds
    } dec_t;

    // Opcode / extension fields
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_JUMP = 4'b1100;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_SHR  = 4'b0100;

    // ALU operation codes (identical to the I-type opcodes)
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1011;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // Branch conditions carried in the Rdest field
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Datapath mux selects; all controls are 2 bits wide, only mux4En uses bit 1
    localparam logic [1:0] MUX4_DST   = 2'b00;
    localparam logic [1:0] MUX4_SIGN  = 2'b01;
    localparam logic [1:0] MUX4_ONE   = 2'b10;
    localparam logic [1:0] MUX4_ZERO  = 2'b11;
    localparam logic [1:0] PCMUX_PC   = 2'b00;
    localparam logic [1:0] PCMUX_SRC  = 2'b01;
    localparam logic [1:0] SEL_ALU    = 2'b00;
    localparam logic [1:0] SEL_SHIFT  = 2'b01;
    localparam logic [1:0] SEL_REG    = 2'b00;
    localparam logic [1:0] SEL_IMM    = 2'b01;
    localparam logic [1:0] SEL_RESULT = 2'b00;
    localparam logic [1:0] SEL_MEMDAT = 2'b01;
    localparam logic [1:0] EN_OFF     = 2'b00;
    localparam logic [1:0] EN_ON      = 2'b01;

    function automatic logic is_ialu(input logic [3:0] op);
        return op inside {ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV};
    endfunction

endpackage

// File: rtl/control_fsm_instr_decoder.sv
// Combinational instruction classifier and branch-condition evaluator.
module instr_decoder
    import control_pkg::*;
(
    input  logic [15:0] instruction,
    input  logic        flag_z,
    input  logic        flag_n,
    output dec_t        dec
);

    logic [3:0] op, ext, cond;
    logic [3:0] unused_rsrc;

    assign op          = instruction[15:12];
    assign cond        = instruction[11:8];
    assign ext         = instruction[7:4];
    assign unused_rsrc = instruction[3:0];

    // Classify the word; anything not matched stays CL_NOP
    always_comb begin
        dec     = '0;
        dec.cls = CL_NOP;
        if (op == OP_RTYPE) begin
            dec.cls    = CL_RALU;
            dec.is_cmp = (ext == EXT_CMP);
        end else if (is_ialu(op)) begin
            dec.cls      = CL_IALU;
            dec.is_cmp   = (op == ALU_CMP);
            dec.sign_ext = !(op inside {ALU_AND, ALU_OR, ALU_XOR});
        end else if (op == OP_SHIFT) begin
            if (ext[3:1] == 3'b000) begin
                dec.cls       = CL_SHIFT;
                dec.shift_imm = 1'b1;
            end else if (ext == EXT_SHR) begin
                dec.cls = CL_SHIFT;
            end
        end else if (op == OP_MEM) begin
            case (ext)
                EXT_LOAD: dec.cls = CL_LOAD;
                EXT_STOR: dec.cls = CL_STOR;
                EXT_JUMP: dec.cls = CL_JUMP;
                default:  dec.cls = CL_NOP;
            endcase
        end else if (op == OP_BCOND) begin
            dec.cls = CL_BCOND;
            case (cond)
                COND_EQ: dec.br_taken = flag_z;
                COND_NE: dec.br_taken = !flag_z;
                COND_LT: dec.br_taken = flag_n;
                COND_AL: dec.br_taken = 1'b1;
                default: dec.br_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU controller: FETCH / DECODE / EXEC / MEM / WB sequencing
// with a req/ready memory handshake.
// Optional: define ILLEGAL_OP_TRAP_EN to add the sticky TRAP state and the
// trap output for undefined opcodes.
module control_fsm
    import control_pkg::*;
#(
    parameter logic [1:0]  PC_INC       = MUX4_ONE,
    parameter int unsigned MEM_WAIT_MAX = 0   // 0: wait for mem_ready forever
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        mem_ready,
    input  logic        flag_z,
    input  logic        flag_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_en,
    output logic        flagRegEn,
    output logic [3:0]  aluControl,
    output logic [1:0]  pcRegEn,
    output logic [1:0]  srcRegEn,
    output logic [1:0]  dstRegEn,
    output logic [1:0]  immRegEn,
    output logic [1:0]  resultRegEn,
    output logic [1:0]  signEn,
    output logic [1:0]  regFileEn,
    output logic [1:0]  pcRegMuxEn,
    output logic [1:0]  mux4En,
    output logic [1:0]  shiftALUMuxEn,
    output logic [1:0]  regImmMuxEn,
    output logic [1:0]  exMemResultEn,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic        trap,
`endif
    output logic [2:0]  state_dbg
);

    state_t state, next_state;
    logic   rst_q;          // high for the cycle following a sampled reset
    logic   wait_expired;
    dec_t   dec;

    instr_decoder u_dec (
        .instruction (instruction),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .dec         (dec)
    );

    // Optional memory-wait watchdog: a nonzero MEM_WAIT_MAX abandons a data
    // access that has not completed within that many cycles.
    if (MEM_WAIT_MAX == 0) begin : g_nowait
        assign wait_expired = 1'b0;
    end else begin : g_wait
        logic [31:0] wait_cnt;
        // Count consecutive MEM cycles without mem_ready
        always_ff @(posedge clk) begin
            if (reset || state != MEM || mem_ready) wait_cnt <= '0;
            else                                    wait_cnt <= wait_cnt + 32'd1;
        end
        assign wait_expired = (state == MEM) && (wait_cnt >= MEM_WAIT_MAX - 1);
    end

    // State register; rst_q masks outputs for the cycle after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            rst_q <= 1'b1;
        end else begin
            state <= next_state;
            rst_q <= 1'b0;
        end
    end

    // Next-state logic; the post-reset cycle never advances the FSM
    always_comb begin
        next_state = state;
        if (rst_q) begin
            next_state = FETCH;
        end else begin
            case (state)
                FETCH:  if (mem_ready) next_state = DECODE;
                DECODE: begin
`ifdef ILLEGAL_OP_TRAP_EN
                    if (dec.cls == CL_NOP) next_state = TRAP;
                    else                   next_state = EXEC;
`else
                    next_state = EXEC;
`endif
                end
                EXEC: begin
                    case (dec.cls)
                        CL_RALU, CL_IALU: next_state = dec.is_cmp ? FETCH : WB;
                        CL_SHIFT:         next_state = WB;
                        CL_LOAD, CL_STOR: next_state = MEM;
                        default:          next_state = FETCH;
                    endcase
                end
                MEM:    if (mem_ready || wait_expired) next_state = FETCH;
                WB:     next_state = FETCH;
                TRAP:   next_state = TRAP;
                default: next_state = FETCH;
            endcase
        end
    end

    // Output decode; everything idles at zero unless the state drives it
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_en         = 1'b0;
        flagRegEn     = 1'b0;
        aluControl    = 4'b0000;
        pcRegEn       = EN_OFF;
        srcRegEn      = EN_OFF;
        dstRegEn      = EN_OFF;
        immRegEn      = EN_OFF;
        resultRegEn   = EN_OFF;
        signEn        = EN_OFF;
        regFileEn     = EN_OFF;
        pcRegMuxEn    = PCMUX_PC;
        mux4En        = MUX4_DST;
        shiftALUMuxEn = SEL_ALU;
        regImmMuxEn   = SEL_REG;
        exMemResultEn = SEL_RESULT;
        if (!rst_q) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_en      = 1'b1;
                        pcRegEn    = EN_ON;
                        mux4En     = PC_INC;
                        pcRegMuxEn = PCMUX_PC;
                        aluControl = ALU_ADD;
                    end
                end
                DECODE: begin
                    srcRegEn = EN_ON;
                    dstRegEn = EN_ON;
                    immRegEn = EN_ON;
                end
                EXEC: begin
                    case (dec.cls)
                        CL_RALU: begin
                            aluControl  = instruction[7:4];
                            mux4En      = MUX4_DST;
                            pcRegMuxEn  = PCMUX_SRC;
                            resultRegEn = EN_ON;
                            flagRegEn   = dec.is_cmp;
                        end
                        CL_IALU: begin
                            aluControl  = instruction[15:12];
                            mux4En      = MUX4_SIGN;
                            signEn      = {1'b0, dec.sign_ext};
                            resultRegEn = EN_ON;
                            flagRegEn   = dec.is_cmp;
                        end
                        CL_SHIFT: begin
                            shiftALUMuxEn = SEL_SHIFT;
                            resultRegEn   = EN_ON;
                            regImmMuxEn   = dec.shift_imm ? SEL_IMM : SEL_REG;
                        end
                        CL_JUMP: begin
                            pcRegEn    = EN_ON;
                            pcRegMuxEn = PCMUX_SRC;
                            mux4En     = MUX4_ZERO;
                            aluControl = ALU_ADD;
                        end
                        CL_BCOND: begin
                            if (dec.br_taken) begin
                                pcRegEn    = EN_ON;
                                mux4En     = MUX4_SIGN;
                                signEn     = EN_ON;
                                pcRegMuxEn = PCMUX_PC;
                                aluControl = ALU_ADD;
                            end
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (dec.cls == CL_STOR);
                    if (mem_ready && dec.cls == CL_LOAD) begin
                        regFileEn     = EN_ON;
                        exMemResultEn = SEL_MEMDAT;
                    end
                end
                WB: begin
                    regFileEn     = EN_ON;
                    exMemResultEn = SEL_RESULT;
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;
`ifdef ILLEGAL_OP_TRAP_EN
    assign trap = (state == TRAP);
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed, table-driven bench for control_fsm. Each table row is one clock
// cycle: inputs applied after the falling edge, outputs compared 1 time unit
// later, well before the next rising edge.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        mem_ready, flag_z, flag_n;
    logic        mem_req, mem_we, ir_en, flagRegEn;
    logic [3:0]  aluControl;
    logic [1:0]  pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn;
    logic [1:0]  regFileEn, pcRegMuxEn, mux4En, shiftALUMuxEn, regImmMuxEn, exMemResultEn;
    logic [2:0]  state_dbg;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        trap;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .flag_z(flag_z), .flag_n(flag_n), .mem_req(mem_req), .mem_we(mem_we),
        .ir_en(ir_en), .flagRegEn(flagRegEn), .aluControl(aluControl),
        .pcRegEn(pcRegEn), .srcRegEn(srcRegEn), .dstRegEn(dstRegEn),
        .immRegEn(immRegEn), .resultRegEn(resultRegEn), .signEn(signEn),
        .regFileEn(regFileEn), .pcRegMuxEn(pcRegMuxEn), .mux4En(mux4En),
        .shiftALUMuxEn(shiftALUMuxEn), .regImmMuxEn(regImmMuxEn),
        .exMemResultEn(exMemResultEn),
`ifdef ILLEGAL_OP_TRAP_EN
        .trap(trap),
`endif
        .state_dbg(state_dbg)
    );

    // Single-bit control flags packed into one word for compact expectations
    localparam logic [15:0] F_MREQ = 16'h0001, F_MWE = 16'h0002, F_IR  = 16'h0004,
                            F_FLG  = 16'h0008, F_PC  = 16'h0010, F_SRC = 16'h0020,
                            F_DST  = 16'h0040, F_IMM = 16'h0080, F_RES = 16'h0100,
                            F_SGN  = 16'h0200, F_RF  = 16'h0400, F_PCM = 16'h0800,
                            F_SHF  = 16'h1000, F_RIM = 16'h2000, F_EXM = 16'h4000,
                            F_HI   = 16'h8000;
    localparam logic [15:0] FOK = F_MREQ | F_IR | F_PC;   // fetch with ready
    localparam logic [15:0] DFL = F_SRC | F_DST | F_IMM;  // decode
    localparam logic [2:0]  FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WS = 3'd4, TR = 3'd5;

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic        rdy, z, n;
        logic [2:0]  st;
        logic [3:0]  alu;
        logic [1:0]  mx;
        logic [15:0] fl;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] act_fl();
        logic hi;
        hi = pcRegEn[1] | srcRegEn[1] | dstRegEn[1] | immRegEn[1] | resultRegEn[1] |
             signEn[1] | regFileEn[1] | pcRegMuxEn[1] | shiftALUMuxEn[1] |
             regImmMuxEn[1] | exMemResultEn[1];
        return {hi, exMemResultEn[0], regImmMuxEn[0], shiftALUMuxEn[0], pcRegMuxEn[0],
                regFileEn[0], signEn[0], resultRegEn[0], immRegEn[0], dstRegEn[0],
                srcRegEn[0], pcRegEn[0], flagRegEn, ir_en, mem_we, mem_req};
    endfunction

    task automatic add(input logic r, input logic [15:0] i, input logic rd, z, n,
                       input logic [2:0] st, input logic [3:0] a, input logic [1:0] m,
                       input logic [15:0] f);
        tbl.push_back('{r, i, rd, z, n, st, a, m, f});
    endtask

    task automatic step(input logic r, input logic [15:0] i, input logic rd, z, n);
        @(negedge clk);
        reset = r; instruction = i; mem_ready = rd; flag_z = z; flag_n = n;
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [3:0] a,
                       input logic [1:0] m, input logic [15:0] f);
        total++;
        if ({state_dbg, aluControl, mux4En, act_fl()} !== {st, a, m, f}) begin
            bad++;
            $display("FAIL %s: got st=%0d alu=%h mux4=%b fl=%h, want st=%0d alu=%h mux4=%b fl=%h",
                     nm, state_dbg, aluControl, mux4En, act_fl(), st, a, m, f);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; instruction = '0; mem_ready = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
        @(posedge clk);

        // reset held two cycles, then released
        add(1, 16'h0000, 0, 0, 0, FE, 4'h0, 2'b00, 16'h0);
        add(0, 16'h0000, 0, 0, 0, FE, 4'h0, 2'b00, 16'h0);
        // ADD R3,R4: fetch wait, then 4-cycle sequence (mem_ready in DECODE/WB ignored)
        add(0, 16'h0354, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        add(0, 16'h0354, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h0354, 1, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h0354, 0, 0, 0, EX, 4'h5, 2'b00, F_PCM | F_RES);
        add(0, 16'h0354, 1, 0, 0, WS, 4'h0, 2'b00, F_RF);
        // LOAD with 3 wait cycles in MEM
        add(0, 16'h4204, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h4204, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h4204, 0, 0, 0, EX, 4'h0, 2'b00, 16'h0);
        add(0, 16'h4204, 0, 0, 0, ME, 4'h0, 2'b00, F_MREQ);
        add(0, 16'h4204, 0, 0, 0, ME, 4'h0, 2'b00, F_MREQ);
        add(0, 16'h4204, 0, 0, 0, ME, 4'h0, 2'b00, F_MREQ);
        add(0, 16'h4204, 1, 0, 0, ME, 4'h0, 2'b00, F_MREQ | F_RF | F_EXM);
        // BEQ taken (Z=1)
        add(0, 16'hC0FE, 1, 1, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'hC0FE, 0, 1, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'hC0FE, 0, 1, 0, EX, 4'h5, 2'b01, F_PC | F_SGN);
        // BEQ not taken (Z=0)
        add(0, 16'hC0FE, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'hC0FE, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'hC0FE, 0, 0, 0, EX, 4'h0, 2'b00, 16'h0);
        // reset during fetch wait; late mem_ready must not fetch
        add(0, 16'hC0FE, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        add(1, 16'hC0FE, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        add(0, 16'hC0FE, 1, 0, 0, FE, 4'h0, 2'b00, 16'h0);
        add(0, 16'hC0FE, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        // STOR, zero-wait
        add(0, 16'h4244, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h4244, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h4244, 0, 0, 0, EX, 4'h0, 2'b00, 16'h0);
        add(0, 16'h4244, 1, 0, 0, ME, 4'h0, 2'b00, F_MREQ | F_MWE);
        add(0, 16'h4244, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        // CMP (R-type): flags, back to FETCH
        add(0, 16'h01B2, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h01B2, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h01B2, 0, 0, 0, EX, 4'hB, 2'b00, F_PCM | F_RES | F_FLG);
        add(0, 16'h01B2, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        // ANDI: zero-extended immediate
        add(0, 16'h1207, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h1207, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h1207, 0, 0, 0, EX, 4'h1, 2'b01, F_RES);
        add(0, 16'h1207, 0, 0, 0, WS, 4'h0, 2'b00, F_RF);
        // ADDI: sign-extended immediate
        add(0, 16'h5207, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h5207, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h5207, 0, 0, 0, EX, 4'h5, 2'b01, F_RES | F_SGN);
        add(0, 16'h5207, 0, 0, 0, WS, 4'h0, 2'b00, F_RF);
        // shift by immediate
        add(0, 16'h8303, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h8303, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h8303, 0, 0, 0, EX, 4'h0, 2'b00, F_SHF | F_RES | F_RIM);
        add(0, 16'h8303, 0, 0, 0, WS, 4'h0, 2'b00, F_RF);
        // shift by register
        add(0, 16'h8342, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h8342, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h8342, 0, 0, 0, EX, 4'h0, 2'b00, F_SHF | F_RES);
        add(0, 16'h8342, 0, 0, 0, WS, 4'h0, 2'b00, F_RF);
        // JUMP
        add(0, 16'h40C5, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'h40C5, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'h40C5, 0, 0, 0, EX, 4'h5, 2'b11, F_PC | F_PCM);
        add(0, 16'h40C5, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
        // BLT taken (N=1)
        add(0, 16'hCC10, 1, 0, 1, FE, 4'h5, 2'b10, FOK);
        add(0, 16'hCC10, 0, 0, 1, DE, 4'h0, 2'b00, DFL);
        add(0, 16'hCC10, 0, 0, 1, EX, 4'h5, 2'b01, F_PC | F_SGN);
        add(0, 16'hCC10, 0, 0, 1, FE, 4'h0, 2'b00, F_MREQ);
        // CMPI
        add(0, 16'hB207, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'hB207, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'hB207, 0, 0, 0, EX, 4'hB, 2'b01, F_RES | F_SGN | F_FLG);
        add(0, 16'hB207, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
`ifndef ILLEGAL_OP_TRAP_EN
        // undefined opcode executes as NOP
        add(0, 16'hF000, 1, 0, 0, FE, 4'h5, 2'b10, FOK);
        add(0, 16'hF000, 0, 0, 0, DE, 4'h0, 2'b00, DFL);
        add(0, 16'hF000, 0, 0, 0, EX, 4'h0, 2'b00, 16'h0);
        add(0, 16'hF000, 0, 0, 0, FE, 4'h0, 2'b00, F_MREQ);
`endif

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].ins, tbl[k].rdy, tbl[k].z, tbl[k].n);
            chk($sformatf("vec%0d", k), tbl[k].st, tbl[k].alu, tbl[k].mx, tbl[k].fl);
        end

        // reset in the middle of a MEM wait abandons the LOAD
        step(0, 16'h4204, 1, 0, 0); chk("rm_fetch", FE, 4'h5, 2'b10, FOK);
        step(0, 16'h4204, 0, 0, 0); chk("rm_dec",   DE, 4'h0, 2'b00, DFL);
        step(0, 16'h4204, 0, 0, 0); chk("rm_exec",  EX, 4'h0, 2'b00, 16'h0);
        step(0, 16'h4204, 0, 0, 0); chk("rm_wait",  ME, 4'h0, 2'b00, F_MREQ);
        step(1, 16'h4204, 0, 0, 0); chk("rm_rst",   ME, 4'h0, 2'b00, F_MREQ);
        step(0, 16'h4204, 1, 0, 0); chk("rm_drop",  FE, 4'h0, 2'b00, 16'h0);
        step(0, 16'h4204, 0, 0, 0); chk("rm_refch", FE, 4'h0, 2'b00, F_MREQ);

`ifdef ILLEGAL_OP_TRAP_EN
        // undefined opcode traps; sticky until reset
        step(0, 16'hF000, 1, 0, 0); chk("tr_fetch", FE, 4'h5, 2'b10, FOK);
        step(0, 16'hF000, 1, 0, 0); chk("tr_dec",   DE, 4'h0, 2'b00, DFL);
        for (int c = 0; c < 10; c++) begin
            step(0, 16'hF000, 1, 0, 0);
            chk($sformatf("tr_hold%0d", c), TR, 4'h0, 2'b00, 16'h0);
            total++;
            if (trap !== 1'b1) begin
                bad++;
                $display("FAIL tr_flag%0d: trap=%b want 1", c, trap);
            end
        end
        step(1, 16'hF000, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 0); chk("tr_clr", FE, 4'h0, 2'b00, 16'h0);
        total++;
        if (trap !== 1'b0) begin
            bad++;
            $display("FAIL tr_clear: trap=%b want 0", trap);
        end
        step(0, 16'h0000, 0, 0, 0); chk("tr_refch", FE, 4'h0, 2'b00, F_MREQ);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle controller that drives the processor datapath's control inputs and consumes the fetched instruction word; it is the control end of the datapath interface.
- Sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK per instruction.
- Handshakes instruction and data memory through a req/ready pair.
- Sits beside the datapath in the CPU top level.

Parameters:
- PC_INC, 2'b10: mux4En code that selects constant 1 for PC increment.
- MEM_WAIT_MAX, 0: reserved; 0 means wait for mem_ready indefinitely.

Ports:
- clk in 1: clock
- reset in 1: synchronous, active-high reset
- instruction in 16: instruction word (OpCode[15:12], Rdest[11:8], OpCodeExt[7:4], Rsrc[3:0], imm[7:0])
- mem_ready in 1: memory has completed the current request (data valid / write accepted)
- flag_z, flag_n in 1: latched PSR flags used for Bcond
- mem_req out 1: memory request
- mem_we out 1: write qualifier for mem_req
- ir_en out 1: latch instruction word
- flagRegEn out 1: update PSR from ALU flags
- aluControl out 4: ALU operation code
- pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, signEn, regFileEn, pcRegMuxEn, mux4En, shiftALUMuxEn, regImmMuxEn, exMemResultEn out 2 each: datapath controls
  - Only mux4En uses bit 1; all others drive bit 1 = 0.
- state_dbg out 3: current state encoding

Behaviour:
- Reset: state = FETCH. All outputs are 0 in the cycle after reset is sampled. A reset during any state, including mid memory wait, drops mem_req and abandons the instruction.
- Default: every output is 0 unless a state drives it (no latches).
- Mux codes:
  - mux4En: 00 dstData, 01 signOut, 10 constant 1, 11 zero.
  - pcRegMuxEn: 0 pc, 1 srcData.
  - shiftALUMuxEn: 0 alu, 1 shift.
  - regImmMuxEn: 0 reg, 1 imm.
  - exMemResultEn: 0 result, 1 memdata.
  - signEn: 1 sign extend, 0 zero extend.
- FETCH:
  - mem_req=1, mem_we=0; hold until mem_ready.
  - On the mem_ready cycle: ir_en=1; pcRegEn=1 with mux4En=PC_INC, pcRegMuxEn=0, aluControl=ADD (pc <= pc+1); go to DECODE.
- DECODE: srcRegEn=dstRegEn=immRegEn=1; classify; go to EXEC.
- EXEC, by class:
  - R-ALU (OpCode 0000): aluControl=OpCodeExt, mux4En=00, pcRegMuxEn=1, resultRegEn=1.
    - CMP (ext 1011): flagRegEn=1, then FETCH.
    - Others: then WB.
  - I-ALU (OpCode in {0101,1001,1011,0001,0010,0011,1101}): aluControl=OpCode, mux4En=01, signEn=1 except AND/OR/XOR (zero-extend), resultRegEn=1; CMPI -> flagRegEn, FETCH; else WB.
  - Shift (OpCode 1000): shiftALUMuxEn=1, resultRegEn=1; regImmMuxEn=1 for ext 000x (immediate), 0 for ext 0100; then WB.
  - LOAD (0100/0000) and STOR (0100/0100): go to MEM.
  - JUMP (0100/1100): pcRegEn=1, pcRegMuxEn=1, mux4En=11, aluControl=ADD; then FETCH.
  - Bcond (1100): condition in Rdest field: 0000 EQ (Z), 0001 NE (!Z), 1100 LT (N), 1110 always, others never.
    - Taken: pcRegEn=1, mux4En=01, signEn=1, pcRegMuxEn=0, ADD.
    - Not taken: no enables.
    - Then FETCH.
- MEM:
  - mem_req=1, mem_we=1 for STOR; wait on mem_ready.
  - LOAD on ready: regFileEn=1, exMemResultEn=1.
  - Then FETCH.
- WB: regFileEn=1, exMemResultEn=0; then FETCH.
- mem_ready outside FETCH/MEM is ignored.
- Latency (cycles, zero-wait memory):
  - ALU/shift: 4 (FETCH, DECODE, EXEC, WB).
  - CMP/branch/jump: 3.
  - LOAD/STOR: 4.
- Undefined opcodes: NOP (DECODE -> EXEC with no enables -> FETCH).

Optional Feature:
- ILLEGAL_OP_TRAP_EN:
  - Defined: adds output trap (1 bit) and state TRAP. An undefined opcode at DECODE enters TRAP, which is sticky: trap=1, all other outputs 0, no fetch. Only reset exits.
  - Undefined: undefined opcodes execute as NOP; no trap port.

Decomposition:
- Package control_pkg:
  - State enum (FETCH, DECODE, EXEC, MEM, WB, TRAP).
  - Opcode/ext constants (OP_RTYPE=0000, OP_MEM=0100, OP_SHIFT=1000, OP_BCOND=1100, EXT_LOAD, EXT_STOR, EXT_JUMP, EXT_CMP).
  - ALU codes (ADD=0101, SUB=1001, CMP=1011, AND=0001, OR=0010, XOR=0011, MOV=1101).
  - Mux select constants.
- One sub-module, instr_decoder: combinational class/condition decode from the instruction word and flags.

Test Plan:
- Reset held 2 cycles then released -> state_dbg=FETCH, mem_req=1, all enables 0.
- ADD R3,R4 (0x0354), mem_ready same cycle -> FETCH(ir_en, pcRegEn) / DECODE / EXEC(aluControl=0101, resultRegEn) / WB(regFileEn, exMemResultEn=0); 4 cycles.
- LOAD (0x4204) with mem_ready delayed 3 cycles in MEM -> mem_req stays 1, mem_we=0 for 3 cycles, then regFileEn=1 and exMemResultEn=1 for one cycle.
- BEQ 0xC0FE: flag_z=1 -> EXEC pcRegEn=1, mux4En=01, signEn=1; flag_z=0 -> no pcRegEn, return to FETCH.
- Reset asserted during FETCH wait -> next cycle mem_req=0, state FETCH; a late mem_ready does not raise ir_en.
- ILLEGAL_OP_TRAP_EN defined, instruction 0xF000 (undefined) -> trap=1 sticky for 10 cycles, mem_req=0, cleared by reset.
